uart_digest_tx_ctrl: RTL and testbench
======================================

Name: uart_digest_tx_ctrl

Overview:
Sequences the single-byte UART transmit shift register (tx_shift_reg) to send a multi-byte digest as back-to-back UART frames. The digest is latched on Start. For each byte, the block presents the byte and releases the shifter's active-low reset. It waits for Empty, then re-asserts the shifter's reset for the inter-byte gap. Sits between the SHA-256 core output and the tx_shift_reg instance. Clk is the bit-rate clock shared with the shifter.

Parameters:
NUM_BYTES, 32, bytes per message; Digest width = 8*NUM_BYTES.
GAP_CYCLES, 1, idle cycles (line held at 1) between frames, range 0..255.
TIMEOUT, 16, max cycles spent in SEND before abort; must be ≥ 13.
IDX_W, 5, width of ByteIdx; must satisfy 2**IDX_W ≥ NUM_BYTES.

Ports:
Clk  in  1  bit-rate clock, shared with tx_shift_reg.
Reset  in  1  synchronous, active-high reset.
Start  in  1  one-cycle request; sampled only in IDLE.
Abort  in  1  synchronous cancel; highest priority after Reset.
Digest  in  8*NUM_BYTES  message; sampled on accepted Start.
Empty  in  1  from tx_shift_reg.Empty.
ByteOut  out  8  to tx_shift_reg.DataIn.
ShiftRst_n  out  1  registered; to tx_shift_reg.Reset (active-low).
ByteIdx  out  IDX_W  index of the byte in flight.
Busy  out  1  high in any state other than IDLE.
Done  out  1  one-cycle pulse after the last frame completes.
Err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; ShiftRst_n=0; ByteOut=0; ByteIdx=0; Busy=0; Done=0; Err=0; shadow digest register=0.
  - The shifter is held in reset, so its TxOut is 1.
- ShiftRst_n:
  - Is a flop. It is 1 only during SEND cycles and 0 in every other state.
  - The shifter must never run outside SEND.
- States: IDLE, LOAD, SEND, GAP, FIN.
- IDLE:
  - On Start=1: latch Digest into the shadow register, set ByteIdx=0 and ByteOut=Digest[8*NUM_BYTES-1 -: 8] (MSB byte first), then go to LOAD.
  - Start is ignored in every non-IDLE state.
- LOAD (1 cycle):
  - ShiftRst_n=0 and ByteOut is stable.
  - Next: SEND; ShiftRst_n←1 at the same edge.
- SEND:
  - ShiftRst_n=1. Timeout counter increments each cycle.
  - The shifter emits the start bit, 8 data bits (LSB first) and the stop bit. Empty rises 11 cycles after release.
  - On Empty=1:
    - ShiftRst_n←0.
    - If ByteIdx==NUM_BYTES-1: go to FIN.
    - Else: ByteIdx←ByteIdx+1, ByteOut←next lower byte, go to GAP (or directly to LOAD if GAP_CYCLES==0).
  - Nominal SEND duration is 12 cycles. Stop bit ≥ 2 cycles including the transition back into reset.
  - If the counter reaches TIMEOUT with Empty still 0: Err=1 for one cycle, ShiftRst_n←0, go to IDLE.
- GAP:
  - Counts GAP_CYCLES cycles with ShiftRst_n=0 (line idles at 1), then goes to LOAD.
- FIN:
  - Done=1 for exactly one cycle, then IDLE. Busy drops together with Done.
- Abort=1 in any state:
  - Next cycle: IDLE, ShiftRst_n=0, no Done/Err pulse, ByteIdx=0.
  - A frame in progress is truncated and the line returns to 1 immediately.
- Simultaneous events:
  - Reset beats Abort; Abort beats Start, Empty and timeout.
  - Start together with Abort in IDLE is not accepted.
- Empty:
  - Ignored outside SEND.
  - Empty=1 in the first SEND cycle is a stale value and must not be treated as completion. Require Empty==1 with timeout counter ≥ 2.
- Digest:
  - May change after Start is accepted; only the shadow copy is transmitted.
- Arithmetic:
  - Byte selection: shadow[8*(NUM_BYTES-1-ByteIdx) +: 8].
  - The timeout counter is wide enough for TIMEOUT and saturates.

Test Plan:
- NUM_BYTES=2, Digest=16'hA55A, Start with a tx_shift_reg model attached -> TxOut carries frames 0xA5 then 0x5A. Each frame: start bit 0, LSB first, stop bit 1. ≥GAP_CYCLES idle 1s between frames. Done pulses once. Busy high from the cycle after Start until Done.
- Full 32-byte digest 0x00..0x1F, GAP_CYCLES=0 -> 32 frames decoded in order 0x00..0x1F, ByteIdx steps 0..31, exactly one Done.
- Empty tied to 0 -> Err pulses exactly TIMEOUT cycles after entering SEND, ShiftRst_n=0, state IDLE, no Done.
- Abort asserted mid-frame of byte 3 -> next cycle ShiftRst_n=0, Busy=0, ByteIdx=0, TxOut=1, no Done/Err. A new Start then restarts from byte 0.
- Start re-pulsed while Busy, and Digest changed after Start -> ignored; the transmitted bytes equal the originally latched digest.
- Reset asserted mid-SEND -> next cycle all outputs at their reset values, TxOut=1.

Source files
------------

// File: rtl/uart_digest_tx_ctrl.sv
// Feeds a latched multi-byte digest, MSB byte first, into a single-byte UART
// shifter by releasing its active-low reset once per frame.
module uart_digest_tx_ctrl #(
  parameter int NUM_BYTES  = 32,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 16,
  parameter int IDX_W      = 5
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Abort,
  input  logic [8*NUM_BYTES-1:0] Digest,
  input  logic                   Empty,
  output logic [7:0]             ByteOut,
  output logic                   ShiftRst_n,
  output logic [IDX_W-1:0]       ByteIdx,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Err
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LIMIT = TCNT_W'(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_MAX   = '1;
  localparam logic [TCNT_W-1:0] TCNT_MIN_DONE = TCNT_W'(2);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, FIN} state_t;

  state_t                 state_reg;
  logic [8*NUM_BYTES-1:0] shadow_reg;
  logic [7:0]             byte_out_reg;
  logic                   shift_rst_n_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   err_reg;
  logic [TCNT_W-1:0]      tcnt_reg;
  logic [7:0]             gap_cnt_reg;

  logic [7:0]       shadow_bytes [NUM_BYTES];
  logic [IDX_W-1:0] idx_next;
  logic             frame_done;
  logic             last_byte;

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
      assign shadow_bytes[gi] = shadow_reg[8*(NUM_BYTES-1-gi) +: 8];
    end
  endgenerate

  assign idx_next  = idx_reg + 1'b1;
  assign last_byte = (idx_reg == IDX_LAST);
  // Empty is left over from the previous frame during the first SEND cycle.
  assign frame_done = Empty && (tcnt_reg >= TCNT_MIN_DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= IDLE;
      shadow_reg      <= '0;
      byte_out_reg    <= '0;
      shift_rst_n_reg <= 1'b0;
      idx_reg         <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      tcnt_reg        <= '0;
      gap_cnt_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (Abort) begin
        state_reg       <= IDLE;
        shift_rst_n_reg <= 1'b0;
        busy_reg        <= 1'b0;
        idx_reg         <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (Start) begin
              shadow_reg   <= Digest;
              idx_reg      <= '0;
              byte_out_reg <= Digest[8*NUM_BYTES-1 -: 8];
              busy_reg     <= 1'b1;
              state_reg    <= LOAD;
            end
          end
          LOAD: begin
            shift_rst_n_reg <= 1'b1;
            tcnt_reg        <= TCNT_W'(1);
            state_reg       <= SEND;
          end
          SEND: begin
            if (frame_done) begin
              shift_rst_n_reg <= 1'b0;
              if (last_byte) begin
                done_reg  <= 1'b1;
                state_reg <= FIN;
              end else begin
                idx_reg      <= idx_next;
                byte_out_reg <= shadow_bytes[idx_next];
                gap_cnt_reg  <= '0;
                state_reg    <= (GAP_CYCLES == 0) ? LOAD : GAP;
              end
            end else if (tcnt_reg >= TCNT_LIMIT) begin
              err_reg         <= 1'b1;
              shift_rst_n_reg <= 1'b0;
              busy_reg        <= 1'b0;
              state_reg       <= IDLE;
            end else if (tcnt_reg != TCNT_MAX) begin
              tcnt_reg <= tcnt_reg + 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
              state_reg <= LOAD;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
          end
          FIN: begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: begin
            shift_rst_n_reg <= 1'b0;
            busy_reg        <= 1'b0;
            state_reg       <= IDLE;
          end
        endcase
      end
    end
  end

  assign ByteOut    = byte_out_reg;
  assign ShiftRst_n = shift_rst_n_reg;
  assign ByteIdx    = idx_reg;
  assign Busy       = busy_reg;
  assign Done       = done_reg;
  assign Err        = err_reg;

endmodule

// File: tb/tb_uart_digest_tx_ctrl.sv
// Randomized bench: a behavioural UART shifter drives TxOut, which is decoded
// and compared against the byte order expected from each latched digest.
module tb_uart_digest_tx_ctrl;
  localparam int NB  = 4;
  localparam int GAP = 1;
  localparam int TO  = 16;
  localparam int IW  = 2;

  logic          Clk = 1'b0;
  logic          Reset, Start, Abort, Empty;
  logic [8*NB-1:0] Digest;
  logic [7:0]    ByteOut;
  logic          ShiftRst_n;
  logic [IW-1:0] ByteIdx;
  logic          Busy, Done, Err;

  uart_digest_tx_ctrl #(.NUM_BYTES(NB), .GAP_CYCLES(GAP), .TIMEOUT(TO), .IDX_W(IW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Digest(Digest),
    .Empty(Empty), .ByteOut(ByteOut), .ShiftRst_n(ShiftRst_n), .ByteIdx(ByteIdx),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  // Behavioural tx_shift_reg: start bit, 8 data bits LSB first, stop bit;
  // Empty rises 11 cycles after reset release and stays high while in reset.
  int         sh_cnt;
  logic       sh_tx, sh_empty, empty_kill;
  logic [7:0] sh_data;
  logic       TxOut;

  always_ff @(posedge Clk) begin
    if (!ShiftRst_n) begin
      sh_cnt   <= 0;
      sh_tx    <= 1'b1;
      sh_empty <= 1'b1;
    end else begin
      if (sh_cnt < 11) sh_cnt <= sh_cnt + 1;
      if (sh_cnt == 0) begin
        sh_data  <= ByteOut;
        sh_tx    <= 1'b0;
        sh_empty <= 1'b0;
      end else if (sh_cnt <= 8) begin
        sh_tx <= sh_data[sh_cnt-1];
      end else if (sh_cnt == 9) begin
        sh_tx <= 1'b1;
      end else if (sh_cnt == 10) begin
        sh_empty <= 1'b1;
      end
    end
  end

  assign TxOut = ShiftRst_n ? sh_tx : 1'b1;
  assign Empty = empty_kill ? 1'b0 : sh_empty;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line monitor state
  int         dec_pos, idle_run, srst_run, done_cnt, err_cnt;
  logic [7:0] dec_byte;
  logic [7:0] got_q[$];
  int         run_q[$];

  task automatic clear_mon();
    dec_pos = 0; idle_run = 0; srst_run = 0; done_cnt = 0; err_cnt = 0;
    got_q.delete(); run_q.delete();
  endtask

  task automatic monitor();
    if (Done === 1'b1) done_cnt++;
    if (Err === 1'b1) err_cnt++;
    if (ShiftRst_n === 1'b1) srst_run++;
    else if (srst_run != 0) begin
      run_q.push_back(srst_run);
      srst_run = 0;
    end
    if (dec_pos == 0) begin
      if (TxOut === 1'b0) begin
        if (got_q.size() > 0) check("gap_idle_ok", 32'(idle_run >= GAP + 1), 1);
        check("idx_at_start", 32'(ByteIdx), 32'(got_q.size()));
        dec_pos  = 1;
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end else if (dec_pos <= 8) begin
      dec_byte[dec_pos-1] = TxOut;
      dec_pos++;
    end else begin
      check("stop_bit", 32'(TxOut), 1);
      got_q.push_back(dec_byte);
      dec_pos  = 0;
      idle_run = 0;
    end
  endtask

  task automatic step();
    @(negedge Clk);
    cyc++;
    monitor();
  endtask

  function automatic logic [8*NB-1:0] rand_digest();
    logic [8*NB-1:0] d;
    for (int b = 0; b < NB; b++) d[8*b +: 8] = 8'($urandom_range(0, 255));
    return d;
  endfunction

  task automatic check_reset_vals(input string where);
    check({where, "_srst_n"}, 32'(ShiftRst_n), 0);
    check({where, "_byteout"}, 32'(ByteOut), 0);
    check({where, "_idx"}, 32'(ByteIdx), 0);
    check({where, "_busy"}, 32'(Busy), 0);
    check({where, "_done"}, 32'(Done), 0);
    check({where, "_err"}, 32'(Err), 0);
    check({where, "_txout"}, 32'(TxOut), 1);
  endtask

  // One full message: digest changes and Start re-pulses while busy are ignored.
  task automatic run_msg(input logic [8*NB-1:0] d);
    logic [8*NB-1:0] tmp;
    logic [7:0]      exp_q[$];
    int              busy_drop, n;
    clear_mon();
    tmp = d;
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(tmp[8*NB-1 -: 8]);
      tmp = tmp << 8;
    end
    Digest = d;
    Start  = 1'b1;
    step();
    Start = 1'b0;
    busy_drop = 0;
    n = 0;
    while (Done !== 1'b1 && n < 400) begin
      if (Busy !== 1'b1) busy_drop++;
      Digest = rand_digest();
      Start  = ($urandom_range(0, 5) == 0);
      step();
      Start = 1'b0;
      n++;
    end
    check("done_seen", 32'(Done), 1);
    check("busy_drop", 32'(busy_drop), 0);
    check("busy_at_done", 32'(Busy), 1);
    step();
    check("busy_after_done", 32'(Busy), 0);
    check("done_count", 32'(done_cnt), 1);
    check("err_count", 32'(err_cnt), 0);
    check("frame_count", 32'(got_q.size()), NB);
    for (int k = 0; k < NB && k < got_q.size(); k++)
      check($sformatf("byte%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
    check("send_count", 32'(run_q.size()), NB);
    for (int k = 0; k < run_q.size(); k++)
      check($sformatf("send_len%0d", k), 32'(run_q[k]), 12);
    $display("msg digest=%h frames=%0d done=%0d", d, got_q.size(), done_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; empty_kill = 1'b0; Digest = '0;
    clear_mon();
    repeat (3) step();
    check_reset_vals("rst");
    Reset = 1'b0;
    step();

    run_msg(32'hA55A_01FE);
    for (int m = 0; m < 5; m++) run_msg(rand_digest());

    // Start together with Abort in IDLE is dropped
    Start = 1'b1; Abort = 1'b1; Digest = rand_digest();
    step();
    Start = 1'b0; Abort = 1'b0;
    check("start_abort_busy", 32'(Busy), 0);
    step();
    check("start_abort_srst", 32'(ShiftRst_n), 0);
    $display("start+abort busy=%0b", Busy);

    // Timeout with Empty stuck low
    clear_mon();
    empty_kill = 1'b1;
    Digest = rand_digest();
    Start = 1'b1;
    step();
    Start = 1'b0;
    n = 0;
    while (ShiftRst_n !== 1'b1 && n < 50) begin step(); n++; end
    c0 = cyc;
    while (Err !== 1'b1 && n < 100) begin step(); n++; end
    check("err_seen", 32'(Err), 1);
    check("err_latency", 32'(cyc - c0), TO);
    check("err_srst", 32'(ShiftRst_n), 0);
    check("err_busy", 32'(Busy), 0);
    empty_kill = 1'b0;
    repeat (3) step();
    check("err_pulses", 32'(err_cnt), 1);
    check("err_no_done", 32'(done_cnt), 0);
    $display("timeout latency=%0d err=%0d", cyc - c0 - 3, err_cnt);

    // Abort in the middle of byte 3
    clear_mon();
    Digest = rand_digest();
    Start = 1'b1;
    step();
    Start = 1'b0;
    n = 0;
    while (!(got_q.size() == 3 && dec_pos == 4) && n < 300) begin step(); n++; end
    check("abort_reached", 32'(got_q.size() == 3 && dec_pos == 4), 1);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    check("abort_srst", 32'(ShiftRst_n), 0);
    check("abort_busy", 32'(Busy), 0);
    check("abort_idx", 32'(ByteIdx), 0);
    check("abort_txout", 32'(TxOut), 1);
    repeat (20) step();
    check("abort_no_done", 32'(done_cnt), 0);
    check("abort_no_err", 32'(err_cnt), 0);
    $display("abort idx=%0d busy=%0b", ByteIdx, Busy);
    run_msg(rand_digest());

    // Reset in the middle of SEND
    clear_mon();
    Digest = rand_digest();
    Start = 1'b1;
    step();
    Start = 1'b0;
    n = 0;
    while (ShiftRst_n !== 1'b1 && n < 50) begin step(); n++; end
    repeat (4) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_reset_vals("midrst");
    $display("mid-send reset srst_n=%0b txout=%0b", ShiftRst_n, TxOut);
    step();
    run_msg(rand_digest());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
